// File: rtl/trial_sequencer.sv
// trial_sequencer: trial-level controller for the hippocampal navigation network.
// Each trial steps iTrial into the start-point lookup and captures the vector it
// returns. That vector drives layer 1 for a fixed window. The network then runs
// until a goal hit or a timeout. After a rest gap the next trial starts, until
// the session ends.
//
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   start          - session start pulse (honoured in IDLE/DONE only)
//   abort          - return to IDLE from any state (highest priority)
//   goal_hit       - goal-cell spike / reward event from the network
//   in_vec         - start-point vector from the lookup (combinational from iTrial)
//   iTrial         - current trial index to the lookup
//   active         - network enable, high in PRESENT and RUN
//   stim_vec       - layer-1 stimulus, the captured vector in PRESENT, else 0
//   trial_done     - one-cycle pulse at the end of each trial
//   trial_success  - qualifies trial_done (1 = goal, 0 = timeout), held
//   run_cycles     - RUN cycles of the last completed trial
//   success_cnt    - successful trials in this session (saturating)
//   busy           - high in LOAD, PRESENT, RUN, REST
//   done           - high in DONE
module trial_sequencer #(
  parameter int unsigned VEC_W       = 6,
  parameter int unsigned N_TRIAL     = 258,
  parameter int unsigned PRESENT_CYC = 16,
  parameter int unsigned MAX_RUN_CYC = 1024,
  parameter int unsigned REST_CYC    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             goal_hit,
  input  logic [VEC_W-1:0] in_vec,
  output logic [9:0]       iTrial,
  output logic             active,
  output logic [VEC_W-1:0] stim_vec,
  output logic             trial_done,
  output logic             trial_success,
  output logic [10:0]      run_cycles,
  output logic [9:0]       success_cnt,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TRIAL_W = 10;
  localparam int unsigned RUNC_W  = 11;
  localparam int unsigned SUCC_W  = 10;

  // One phase counter is shared by PRESENT, RUN and REST; size it for the longest.
  localparam int unsigned CNT_MAX_PR = (PRESENT_CYC > REST_CYC) ? PRESENT_CYC : REST_CYC;
  localparam int unsigned CNT_MAX    = (MAX_RUN_CYC > CNT_MAX_PR) ? MAX_RUN_CYC : CNT_MAX_PR;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   PRESENT_LAST = CNT_W'(PRESENT_CYC - 1);
  localparam logic [CNT_W-1:0]   RUN_LAST     = CNT_W'(MAX_RUN_CYC);
  localparam logic [CNT_W-1:0]   REST_LAST    = CNT_W'(REST_CYC - 1);
  localparam logic [TRIAL_W-1:0] LAST_TRIAL   = TRIAL_W'(N_TRIAL - 1);
  localparam logic [SUCC_W-1:0]  SUCC_SAT     = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRESENT,
    S_RUN,
    S_REST,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   start_vec_q, start_vec_d;
  logic [TRIAL_W-1:0] itrial_q, itrial_d;
  logic               active_q, active_d;
  logic [VEC_W-1:0]   stim_vec_q, stim_vec_d;
  logic               trial_done_q, trial_done_d;
  logic               trial_success_q, trial_success_d;
  logic [RUNC_W-1:0]  run_cycles_q, run_cycles_d;
  logic [SUCC_W-1:0]  success_cnt_q, success_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               trial_end;
  logic               session_start;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything else
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) state_d = S_LOAD;
        end
        S_LOAD: begin
          state_d = S_PRESENT;
        end
        S_PRESENT: begin
          if (cnt_q == PRESENT_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (goal_hit || (cnt_q == RUN_LAST)) state_d = S_REST;
        end
        S_REST: begin
          if (cnt_q == REST_LAST) begin
            state_d = (itrial_q == LAST_TRIAL) ? S_DONE : S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values, derived from the state transition
  always_comb begin
    session_start   = ((state_q == S_IDLE) || (state_q == S_DONE)) && (state_d == S_LOAD);
    trial_end       = (state_q == S_RUN) && (state_d == S_REST);

    cnt_d           = cnt_q;
    start_vec_d     = start_vec_q;
    itrial_d        = itrial_q;
    trial_done_d    = 1'b0;
    trial_success_d = trial_success_q;
    run_cycles_d    = run_cycles_q;
    success_cnt_d   = success_cnt_q;

    // RUN counts from 1 so run_cycles reads directly as the cycle count.
    if (state_d != state_q) begin
      cnt_d = (state_d == S_RUN) ? CNT_W'(1) : '0;
    end else if ((state_q == S_PRESENT) || (state_q == S_RUN) || (state_q == S_REST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    if (state_q == S_LOAD) begin
      start_vec_d = in_vec;
    end

    if (session_start) begin
      itrial_d      = '0;
      success_cnt_d = '0;
    end else if ((state_q == S_REST) && (state_d == S_LOAD)) begin
      itrial_d = itrial_q + TRIAL_W'(1);
    end

    if (trial_end) begin
      trial_done_d    = 1'b1;
      trial_success_d = goal_hit;
      run_cycles_d    = RUNC_W'(cnt_q);
      if (goal_hit && (success_cnt_q != SUCC_SAT)) begin
        success_cnt_d = success_cnt_q + SUCC_W'(1);
      end
    end

    active_d = (state_d == S_PRESENT) || (state_d == S_RUN);
    busy_d   = (state_d == S_LOAD) || (state_d == S_PRESENT) ||
               (state_d == S_RUN)  || (state_d == S_REST);
    done_d   = (state_d == S_DONE);

    // The first PRESENT cycle is driven straight from in_vec, which is captured on the same edge.
    if (state_d == S_PRESENT) begin
      stim_vec_d = (state_q == S_LOAD) ? in_vec : start_vec_q;
    end else begin
      stim_vec_d = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q           <= '0;
      start_vec_q     <= '0;
      itrial_q        <= '0;
      active_q        <= 1'b0;
      stim_vec_q      <= '0;
      trial_done_q    <= 1'b0;
      trial_success_q <= 1'b0;
      run_cycles_q    <= '0;
      success_cnt_q   <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      start_vec_q     <= start_vec_d;
      itrial_q        <= itrial_d;
      active_q        <= active_d;
      stim_vec_q      <= stim_vec_d;
      trial_done_q    <= trial_done_d;
      trial_success_q <= trial_success_d;
      run_cycles_q    <= run_cycles_d;
      success_cnt_q   <= success_cnt_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign iTrial        = itrial_q;
  assign active        = active_q;
  assign stim_vec      = stim_vec_q;
  assign trial_done    = trial_done_q;
  assign trial_success = trial_success_q;
  assign run_cycles    = run_cycles_q;
  assign success_cnt   = success_cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_trial_sequencer.sv
// Bench for trial_sequencer with a short session (3 trials, 8-cycle run limit).
module tb_trial_sequencer;

  localparam int P    = 16;
  localparam int MAXR = 8;
  localparam int REST = 32;
  localparam int NTR  = 3;

  localparam logic [5:0] V0 = 6'b010001;
  localparam logic [5:0] V1 = 6'b101010;

  typedef struct packed {
    logic [9:0]  itrial;
    logic        active;
    logic [5:0]  stim;
    logic        td;
    logic        ts;
    logic [10:0] rc;
    logic [9:0]  sc;
    logic        busy;
    logic        done;
  } outs_t;

  typedef struct {
    logic  start;
    logic  abort;
    logic  goal;
    int    cycles;
    outs_t exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        goal_hit;
  logic [5:0]  in_vec;
  logic [9:0]  iTrial;
  logic        active;
  logic [5:0]  stim_vec;
  logic        trial_done;
  logic        trial_success;
  logic [10:0] run_cycles;
  logic [9:0]  success_cnt;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  trial_sequencer #(
    .VEC_W(6), .N_TRIAL(NTR), .PRESENT_CYC(P), .MAX_RUN_CYC(MAXR), .REST_CYC(REST)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .goal_hit(goal_hit),
    .in_vec(in_vec), .iTrial(iTrial), .active(active), .stim_vec(stim_vec),
    .trial_done(trial_done), .trial_success(trial_success), .run_cycles(run_cycles),
    .success_cnt(success_cnt), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start-point lookup stand-in
  function automatic logic [5:0] lut(input logic [9:0] i);
    case (i[1:0])
      2'd0:    lut = V0;
      2'd1:    lut = V1;
      2'd2:    lut = 6'b110011;
      default: lut = 6'b001100;
    endcase
  endfunction

  always_comb in_vec = lut(iTrial);

  outs_t act;
  assign act = {iTrial, active, stim_vec, trial_done, trial_success, run_cycles,
                success_cnt, busy, done};

  function automatic outs_t o(input logic [9:0] it, input logic ac, input logic [5:0] sv,
                              input logic td, input logic ts, input logic [10:0] rc,
                              input logic [9:0] sc, input logic bz, input logic dn);
    outs_t r;
    r.itrial = it; r.active = ac; r.stim = sv; r.td = td; r.ts = ts;
    r.rc = rc; r.sc = sc; r.busy = bz; r.done = dn;
    return r;
  endfunction

  function automatic string fmt(input outs_t v);
    return $sformatf("iTrial=%0d active=%b stim=%b td=%b ts=%b rc=%0d sc=%0d busy=%b done=%b",
                     v.itrial, v.active, v.stim, v.td, v.ts, v.rc, v.sc, v.busy, v.done);
  endfunction

  function automatic vec_t mkv(input logic s, input logic a, input logic g, input int c,
                               input outs_t e);
    vec_t v;
    v.start = s; v.abort = a; v.goal = g; v.cycles = c; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input outs_t exp, input bit verbose);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (verbose) $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  // Inputs are held for the first edge only, then idle for the rest of the step
  task automatic apply(input logic s, input logic a, input logic g, input int cycles);
    start = s; abort = a; goal_hit = g;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; goal_hit = 1'b0;
    for (int k = 1; k < cycles; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // Reference model: one trial is a timeline measured from its LOAD cycle (t = 0)
  int          m_sess;      // 0 idle, 1 in session, 2 finished
  int          m_t;
  int          m_run_len;   // 0 while the run is still open
  int          m_trial;
  int          m_succ;
  int          m_last_run;
  bit          m_last_succ;
  bit          m_pulse;

  task automatic m_reset();
    m_sess = 0; m_t = 0; m_run_len = 0; m_trial = 0; m_succ = 0;
    m_last_run = 0; m_last_succ = 1'b0; m_pulse = 1'b0;
  endtask

  function automatic outs_t m_outs();
    outs_t r;
    bit in_s;
    in_s     = (m_sess == 1);
    r.itrial = 10'(m_trial);
    r.active = in_s && (m_t >= 1) && ((m_t <= P) || (m_run_len == 0));
    r.stim   = (in_s && (m_t >= 1) && (m_t <= P)) ? lut(10'(m_trial)) : 6'd0;
    r.td     = m_pulse;
    r.ts     = m_last_succ;
    r.rc     = 11'(m_last_run);
    r.sc     = 10'(m_succ);
    r.busy   = in_s;
    r.done   = (m_sess == 2);
    return r;
  endfunction

  task automatic m_step(input bit st, input bit ab, input bit gl);
    int rc;
    m_pulse = 1'b0;
    if (ab) begin
      m_sess = 0;
      return;
    end
    if (m_sess != 1) begin
      if (st) begin
        m_sess = 1; m_trial = 0; m_succ = 0; m_t = 0; m_run_len = 0;
      end
      return;
    end
    if ((m_t > P) && (m_run_len == 0)) begin
      rc = m_t - P;
      if (gl || (rc == MAXR)) begin
        m_run_len   = rc;
        m_pulse     = 1'b1;
        m_last_succ = gl;
        m_last_run  = rc;
        if (gl && (m_succ < 1023)) m_succ++;
      end
    end else if ((m_run_len != 0) && (m_t == P + m_run_len + REST)) begin
      if (m_trial == NTR - 1) begin
        m_sess = 2;
      end else begin
        m_trial++; m_t = 0; m_run_len = 0;
      end
      return;
    end
    m_t++;
  endtask

  vec_t vecs[$];

  initial begin
    bit st, ab, gl;
    int fail_prints;

    reset = 1'b1; start = 1'b0; abort = 1'b0; goal_hit = 1'b0;

    // Session: trial 0 goal on RUN 5, trial 1 timeout, trial 2 goal on RUN 8, restart
    vecs.push_back(mkv(1, 0, 0,  1, o(0, 0, 6'd0, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mkv(0, 0, 0,  1, o(0, 1, V0,   0, 0, 0, 0, 1, 0)));
    vecs.push_back(mkv(0, 0, 0, 15, o(0, 1, V0,   0, 0, 0, 0, 1, 0)));
    vecs.push_back(mkv(0, 0, 0,  1, o(0, 1, 6'd0, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mkv(0, 0, 0,  4, o(0, 1, 6'd0, 0, 0, 0, 0, 1, 0)));
    vecs.push_back(mkv(0, 0, 1,  1, o(0, 0, 6'd0, 1, 1, 5, 1, 1, 0)));
    vecs.push_back(mkv(0, 0, 0,  1, o(0, 0, 6'd0, 0, 1, 5, 1, 1, 0)));
    vecs.push_back(mkv(0, 0, 0, 30, o(0, 0, 6'd0, 0, 1, 5, 1, 1, 0)));
    vecs.push_back(mkv(0, 0, 0,  1, o(1, 0, 6'd0, 0, 1, 5, 1, 1, 0)));
    vecs.push_back(mkv(0, 0, 0,  1, o(1, 1, V1,   0, 1, 5, 1, 1, 0)));
    vecs.push_back(mkv(0, 0, 0, 23, o(1, 1, 6'd0, 0, 1, 5, 1, 1, 0)));
    vecs.push_back(mkv(0, 0, 0,  1, o(1, 0, 6'd0, 1, 0, 8, 1, 1, 0)));
    vecs.push_back(mkv(0, 0, 0, 32, o(2, 0, 6'd0, 0, 0, 8, 1, 1, 0)));
    vecs.push_back(mkv(0, 0, 0, 24, o(2, 1, 6'd0, 0, 0, 8, 1, 1, 0)));
    vecs.push_back(mkv(0, 0, 1,  1, o(2, 0, 6'd0, 1, 1, 8, 2, 1, 0)));
    vecs.push_back(mkv(0, 0, 0, 32, o(2, 0, 6'd0, 0, 1, 8, 2, 0, 1)));
    vecs.push_back(mkv(0, 0, 0,  5, o(2, 0, 6'd0, 0, 1, 8, 2, 0, 1)));
    vecs.push_back(mkv(1, 0, 0,  1, o(0, 0, 6'd0, 0, 1, 8, 0, 1, 0)));

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_state", o(0, 0, 6'd0, 0, 0, 0, 0, 0, 0), 1'b1);

    foreach (vecs[i]) begin
      apply(vecs[i].start, vecs[i].abort, vecs[i].goal, vecs[i].cycles);
      check($sformatf("vec%0d", i), vecs[i].exp, 1'b1);
    end

    // start and goal_hit during PRESENT are ignored
    apply(0, 0, 0, 3);
    apply(1, 0, 1, 1);
    check("start_in_present", o(0, 1, V0, 0, 1, 8, 0, 1, 0), 1'b1);
    apply(0, 0, 0, 12);
    check("present_last", o(0, 1, V0, 0, 1, 8, 0, 1, 0), 1'b1);
    apply(0, 0, 0, 1);
    check("run_first", o(0, 1, 6'd0, 0, 1, 8, 0, 1, 0), 1'b1);
    apply(0, 0, 1, 1);
    check("goal_run1", o(0, 0, 6'd0, 1, 1, 1, 1, 1, 0), 1'b1);
    apply(0, 0, 0, 32);
    check("load_trial1", o(1, 0, 6'd0, 0, 1, 1, 1, 1, 0), 1'b1);
    apply(0, 0, 0, 17);
    check("run1_trial1", o(1, 1, 6'd0, 0, 1, 1, 1, 1, 0), 1'b1);

    // abort in RUN beats goal_hit and start
    apply(0, 0, 0, 3);
    apply(1, 1, 1, 1);
    check("abort_run", o(1, 0, 6'd0, 0, 1, 1, 1, 0, 0), 1'b1);
    apply(0, 0, 0, 1);
    check("abort_hold", o(1, 0, 6'd0, 0, 1, 1, 1, 0, 0), 1'b1);

    // reset in REST clears everything without a pulse
    apply(1, 0, 0, 1);
    check("restart_idle", o(0, 0, 6'd0, 0, 1, 1, 0, 1, 0), 1'b1);
    apply(0, 0, 0, 17);
    apply(0, 0, 1, 1);
    check("goal_before_rst", o(0, 0, 6'd0, 1, 1, 1, 1, 1, 0), 1'b1);
    apply(0, 0, 0, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_in_rest", o(0, 0, 6'd0, 0, 0, 0, 0, 0, 0), 1'b1);
    apply(0, 0, 0, 1);
    check("reset_in_rest_hold", o(0, 0, 6'd0, 0, 0, 0, 0, 0, 0), 1'b1);

    // Random traffic against the timeline model
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset();
    fail_prints = 0;
    for (int c = 0; c < 3000; c++) begin
      n_checks++;
      if (act !== m_outs()) begin
        n_errors++;
        if (fail_prints < 10) begin
          fail_prints++;
          $display("FAIL rand_c%0d: got {%s} expected {%s}", c, fmt(act), fmt(m_outs()));
        end
      end
      st = (m_sess == 1) ? ($urandom_range(19) == 0) : ($urandom_range(7) == 0);
      ab = ($urandom_range(399) == 0);
      gl = ($urandom_range(6) == 0);
      start = st; abort = ab; goal_hit = gl;
      m_step(st, ab, gl);
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; goal_hit = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trial_sequencer.md
Name: trial_sequencer

Overview:
- Trial-level controller for the hippocampal navigation network.
- Steps the trial index into the start-point lookup and captures the start-point vector it returns.
- Presents that vector to layer 1 for a fixed window, then lets the network run until a goal hit or a timeout, enforces a rest gap, and advances to the next trial until the session ends.
- Sits between the host/testbench session control and the start-point lookup / layer-1 input.

Parameters:
- VEC_W, 6, width of the start-point vector (equals Neurons_Layer1).
- N_TRIAL, 258, trials per session; valid iTrial range is 0..N_TRIAL-1.
- PRESENT_CYC, 16, cycles the start vector is driven to layer 1.
- MAX_RUN_CYC, 1024, RUN-phase cycle limit before a timeout is declared.
- REST_CYC, 32, inter-trial quiet cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  session start pulse; honoured only in IDLE or DONE.
- abort  in  1  returns the block to IDLE from any state.
- goal_hit  in  1  goal-cell spike or reward event from the network.
- in_vec  in  VEC_W  start-point vector from the lookup, driven combinationally from iTrial.
- iTrial  out  10  current trial index to the lookup.
- active  out  1  network enable; high in PRESENT and RUN.
- stim_vec  out  VEC_W  layer-1 stimulus; equals the captured vector in PRESENT, 0 otherwise.
- trial_done  out  1  one-cycle pulse when a trial ends.
- trial_success  out  1  qualifies trial_done: 1 = goal, 0 = timeout.
- run_cycles  out  11  RUN cycles of the last completed trial (goal or timeout).
- success_cnt  out  10  successful trials in the current session.
- busy  out  1  high in LOAD, PRESENT, RUN and REST.
- done  out  1  high in DONE.

Behaviour:
- All outputs and state are registered.
- Reset: state=IDLE; iTrial, stim_vec, run_cycles, success_cnt, all counters = 0; active, trial_done, trial_success, busy, done = 0.
- States: IDLE, LOAD, PRESENT, RUN, REST, DONE.
- IDLE/DONE, start=1:
  - iTrial<=0, success_cnt<=0; go to LOAD next cycle.
  - done drops on leaving DONE.
- LOAD (1 cycle):
  - iTrial is already stable, so in_vec has settled.
  - Capture in_vec into start_vec; go to PRESENT.
- PRESENT:
  - active=1, stim_vec=start_vec.
  - Exactly PRESENT_CYC cycles, then RUN.
  - goal_hit is ignored in PRESENT.
- RUN:
  - active=1, stim_vec=0.
  - run counter starts at 1 on the first RUN cycle.
  - goal_hit=1 ends the trial with success.
  - If the counter equals MAX_RUN_CYC with no goal, the trial ends with timeout.
  - goal_hit on the timeout cycle counts as success.
- Trial end (RUN→REST edge):
  - trial_done=1 for one cycle; trial_success set accordingly and held until the next trial_done.
  - run_cycles<=counter value (1..MAX_RUN_CYC).
  - success_cnt increments on success and saturates at 1023.
- REST:
  - active=0, stim_vec=0, for REST_CYC cycles.
  - At the end: if iTrial==N_TRIAL-1, go to DONE with iTrial held; else iTrial<=iTrial+1 and go to LOAD.
- DONE: done=1; outputs hold until start or abort.
- abort=1 in any state:
  - Next state IDLE; active and stim_vec go to 0 on the next edge.
  - No trial_done is generated; iTrial, success_cnt and run_cycles are held.
  - abort takes precedence over start and goal_hit.
- start outside IDLE/DONE is ignored; start in DONE restarts the session.
- reset mid-trial behaves identically to power-up reset, with no pulses emitted.
- Timing, with start sampled at edge 0:
  - LOAD is cycle 1.
  - PRESENT is cycles 2..1+PRESENT_CYC.
  - First RUN cycle is 2+PRESENT_CYC.

Test Plan:
- Reset, then start, with in_vec tracking a model lookup (iTrial 0→6'b010001), PRESENT_CYC=16 -> stim_vec=6'b010001 for cycles 2..17; active 2..; first RUN cycle 18 with stim_vec=0.
- goal_hit on the 5th RUN cycle -> trial_done pulse one cycle later, trial_success=1, run_cycles=5, success_cnt=1; after 32 REST cycles iTrial=1 and LOAD.
- No goal_hit, MAX_RUN_CYC=8 -> timeout after RUN cycle 8, trial_success=0, run_cycles=8, success_cnt unchanged; goal_hit exactly on cycle 8 instead -> success.
- N_TRIAL=3, goal on every trial -> iTrial 0,1,2; DONE with done=1, iTrial=2, success_cnt=3; a second start -> iTrial=0, success_cnt=0.
- abort during RUN of trial 1 -> IDLE next cycle, active=0, no trial_done, iTrial=1 held; start in PRESENT is ignored (no restart).
- Reset asserted mid-REST -> all outputs 0 next cycle, state IDLE, no trial_done pulse.
